// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter and the divider it sits beside:
// FSM state encoding, default counter width and the system clock rate.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_COUNT     = 2'd2
  } state_e;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int SYSCLK_HZ     = 100_000_000;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchronizer chain for an asynchronous input plus a rising-edge detector
// on the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;

  // Shift the raw input through the chain and keep one delayed copy of s.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_r <= '0;
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      s_d_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign s    = sync_r[SYNC_STAGES-1];
  assign rise = s & ~s_d_r;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow external signal in sysclk cycles.
// Defining PERIOD_METER_HIGH_TIME_EN adds high_out, the high time per period.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 overflow,
  output logic                 busy
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_WIDTH-1:0] high_out
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 sync_s;
  logic                 rise_s;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .sysclk(sysclk),
    .reset (reset),
    .d     (sig_in),
    .s     (sync_s),
    .rise  (rise_s)
  );

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_WIDTH-1:0] hi_cnt_r;
  logic [CNT_WIDTH-1:0] s_ext_s;
  assign s_ext_s = {{(CNT_WIDTH-1){1'b0}}, sync_s};

  // High-time counter: restarts with s on each rise, saturates at CNT_MAX.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      hi_cnt_r <= '0;
      high_out <= '0;
    end else if (!enable || state_r == ST_IDLE) begin
      hi_cnt_r <= '0;
    end else if (state_r == ST_WAIT_EDGE) begin
      if (rise_s) hi_cnt_r <= s_ext_s;
    end else if (rise_s) begin
      high_out <= hi_cnt_r;
      hi_cnt_r <= s_ext_s;
    end else if (cnt_r == CNT_MAX) begin
      high_out <= hi_cnt_r;
      hi_cnt_r <= '0;
    end else if (hi_cnt_r != CNT_MAX) begin
      hi_cnt_r <= hi_cnt_r + s_ext_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = sync_s;
`endif

  // Measurement FSM; a rise in COUNT outranks a same-cycle timeout.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else if (!enable) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      period_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      busy         <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT_EDGE;
        end
        ST_WAIT_EDGE: begin
          if (rise_s) begin
            cnt_r   <= CNT_ONE;
            state_r <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (rise_s) begin
            period_out   <= cnt_r;
            overflow     <= 1'b0;
            period_valid <= 1'b1;
            cnt_r        <= CNT_ONE;
          end else if (cnt_r == CNT_MAX) begin
            period_out   <= CNT_MAX;
            overflow     <= 1'b1;
            period_valid <= 1'b1;
            cnt_r        <= '0;
            state_r      <= ST_WAIT_EDGE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an external, slower input signal in sysclk cycles; the receiving counterpart of a clock divider.
- Typical use: confirm a 10 kHz divided clock reads 10000 periods at 100 MHz sysclk, or time external pulses.
- Sits beside the divider and tester logic; results feed the display/compare logic as a count plus a one-cycle valid strobe.

Parameters:
- CNT_WIDTH, 16, width of period counter and period_out; max measurable period 2^CNT_WIDTH-1 cycles.
- SYNC_STAGES, 2, synchronizer flops on sig_in (legal range 2..4).

Ports:
- sysclk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = measure; 0 = abort and idle.
- sig_in  input  1  asynchronous signal under measurement.
- period_out  output  CNT_WIDTH  last measured period in sysclk cycles.
- period_valid  output  1  one-cycle strobe when period_out/overflow update.
- overflow  output  1  1 = last result timed out (no edge within max count).
- busy  output  1  1 when state != IDLE.

Behaviour:
- Reset (sync, active-high, sampled at posedge sysclk):
  - state=IDLE, cnt=0, all sync/edge flops=0.
  - period_out=0, period_valid=0, overflow=0, busy=0.
- Input path:
  - sig_in passes through SYNC_STAGES flops giving s; one more flop gives s_d; rise = s & ~s_d.
  - A clean sig_in rise produces rise SYNC_STAGES+1 cycles later.
- States: IDLE, WAIT_EDGE, COUNT.
- IDLE: cnt=0. enable=1 -> WAIT_EDGE next cycle.
- WAIT_EDGE: ignore everything until rise. On rise: cnt<=1, go to COUNT. No result is emitted for this first edge.
- COUNT, no rise and cnt<MAX: cnt<=cnt+1.
- COUNT, rise: period_out<=cnt, overflow<=0, period_valid<=1 for one cycle, cnt<=1, stay in COUNT (back-to-back measurements).
  - Two rises P cycles apart yield period_out=P exactly.
- COUNT, cnt==MAX and no rise: period_out<=MAX, overflow<=1, period_valid<=1, go to WAIT_EDGE.
- COUNT, cnt==MAX and rise in the same cycle: rise wins; normal result period_out=MAX, overflow=0.
- enable=0 in any state: go to IDLE next cycle, cnt<=0, no strobe. period_out/overflow hold last values. Re-enable restarts from WAIT_EDGE, so the first edge again gives no result.
- reset during any state overrides everything, including a same-cycle rise or timeout.
- Arithmetic: unsigned; cnt never wraps.
- Minimum measurable period: 2 cycles, limited by the edge detector.
- Outputs are registered; period_valid is 1 in the cycle after the rise is detected.

Optional Feature:
- Macro: PERIOD_METER_HIGH_TIME_EN.
- When defined:
  - Adds output high_out [CNT_WIDTH].
  - A second counter counts cycles with s==1 inside the current period window, saturating at MAX.
  - On each period_valid it latches into high_out and the counter clears. Cycle convention: it loads s on the rise cycle, so a 50% duty signal gives high_out=P/2.
  - Reset value of high_out is 0; it holds when enable=0.
  - On timeout it latches the saturated/partial count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT_EDGE=2'd1, ST_COUNT=2'd2.
  - default CNT_WIDTH.
  - the 100 MHz sysclk frequency constant, shared with the divider.
- One sub-module, edge_sync: SYNC_STAGES synchronizer plus rise detector. Ports: sysclk, reset, d, s, rise.

Test Plan:
- 100 MHz sysclk, sig_in = 10 kHz square wave (toggle every 5000 cycles), enable=1 -> first edge gives no strobe; every later rise gives period_valid with period_out=10000 and overflow=0.
- sig_in toggling every 2 cycles (period 4) -> continuous results of 4; toggling every cycle (period 2) -> results of 2.
- CNT_WIDTH=16, one rise then sig_in held low -> 65535 cycles after the rise: period_valid, period_out=65535, overflow=1; the next two rises 300 cycles apart -> 300, overflow=0.
- enable dropped 1234 cycles into COUNT -> no strobe, busy=0 next cycle, period_out unchanged; re-enable -> first edge gives no result, the second edge gives the correct period.
- reset asserted in COUNT on the same cycle as a rise -> no strobe; all outputs 0 the next cycle; state IDLE.
- With PERIOD_METER_HIGH_TIME_EN, 10 kHz at 25% duty -> period_out=10000, high_out=2500 on each strobe.
